// File: rtl/mdio_master.sv
// -----------------------------------------------------------------------------
// mdio_master
//
// Clause-22 MDIO management master. Generates MDC from mclk and serialises one
// PHY register read or write frame per accepted request.
//
// Frame (MSB first): [32 x 1 preamble] ST(01) OP(10 rd / 01 wr) PHY[4:0]
// REG[4:0] TA DATA[15:0]. On a write the master drives TA = 10 and the data.
// On a read it releases the pad for TA and DATA and samples the PHY.
//
// Each bit is a low phase of D+1 mclk cycles followed by a high phase of D+1
// cycles, where D is cfg_clk_div latched at acceptance. mdio_out and
// mdio_out_en change only on the edge that starts a low phase (MDC fall).
// Read data is sampled on the last mclk edge of each high phase.
//
// Ports:
//   mclk, reset      block clock; asynchronous active-high reset
//   cfg_clk_div      MDC half-period minus one, in mclk cycles
//   cfg_pre_en       1 = send the 32-bit preamble
//   req_valid/ready  request handshake; req_ready = !busy
//   req_rd           1 = read, 0 = write
//   req_phy, req_reg PHY and register address
//   req_wdata        write data
//   rsp_valid        one-cycle pulse at transaction end
//   rsp_rdata        read data, held until the next read completes
//   rsp_err          read TA check failed (PHY did not pull TA bit 2 low)
//   busy             transaction in progress
//   mdio_clk         MDC to pad
//   mdio_out         MDIO data to pad
//   mdio_out_en      pad output enable, active-low (0 drives, 1 releases)
//   mdio_in          MDIO data from pad, asynchronous
// -----------------------------------------------------------------------------
module mdio_master #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [DIV_W-1:0] cfg_clk_div,
  input  logic             cfg_pre_en,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rd,
  input  logic [4:0]       req_phy,
  input  logic [4:0]       req_reg,
  input  logic [15:0]      req_wdata,
  output logic             rsp_valid,
  output logic [15:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic             mdio_clk,
  output logic             mdio_out,
  output logic             mdio_out_en,
  input  logic             mdio_in
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_TA   = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;

  // Number of bits in each multi-bit state, minus one.
  localparam logic [5:0] PRE_LAST  = 6'd31;
  localparam logic [5:0] HDR_LAST  = 6'd13;
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'd15;

  logic [2:0]       r_state;
  logic             r_rd;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_mdc;
  logic [5:0]       r_bit_cnt;
  logic [31:0]      r_shift;
  logic             r_out;
  logic             r_out_en;
  logic             r_sync1;
  logic             r_sync2;
  logic [15:0]      r_rd_shift;
  logic             r_ta_err;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_rdata;
  logic             r_rsp_err;

  logic             w_busy;
  logic             w_accept;
  logic             w_phase_end;
  logic             w_bit_end;
  logic [1:0]       w_op;
  logic [1:0]       w_ta;
  logic [15:0]      w_data;
  logic [31:0]      w_frame;
  logic [31:0]      w_shift_next;

  assign w_busy      = (r_state != S_IDLE);
  assign w_accept    = req_valid & ~w_busy;
  assign w_phase_end = (r_div_cnt == r_div);
  // The last cycle of a high phase closes the current bit.
  assign w_bit_end   = w_phase_end & r_mdc;

  // Everything after the preamble. For reads the TA/DATA slots are don't-care
  // because the pad is released; zeros keep mdio_out quiet.
  assign w_op    = req_rd ? 2'b10 : 2'b01;
  assign w_ta    = req_rd ? 2'b00 : 2'b10;
  assign w_data  = req_rd ? 16'h0000 : req_wdata;
  assign w_frame = {2'b01, w_op, req_phy, req_reg, w_ta, w_data};

  assign w_shift_next = {r_shift[30:0], 1'b0};

  // Two-flop synchroniser for the asynchronous pad input.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= mdio_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rd        <= 1'b0;
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_mdc       <= 1'b0;
      r_bit_cnt   <= 6'd0;
      r_shift     <= 32'h0;
      r_out       <= 1'b0;
      r_out_en    <= 1'b1;
      r_rd_shift  <= 16'h0;
      r_ta_err    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 16'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;

      if (w_accept) begin
        r_state    <= cfg_pre_en ? S_PRE : S_HDR;
        r_rd       <= req_rd;
        r_div      <= cfg_clk_div;
        r_div_cnt  <= '0;
        r_mdc      <= 1'b0;
        r_bit_cnt  <= 6'd0;
        r_out_en   <= 1'b0;
        r_rd_shift <= 16'h0;
        r_ta_err   <= 1'b0;
        // The first bit goes out on the acceptance edge itself.
        if (cfg_pre_en) begin
          r_out   <= 1'b1;
          r_shift <= w_frame;
        end else begin
          r_out   <= w_frame[31];
          r_shift <= {w_frame[30:0], 1'b0};
        end
      end else if (w_busy) begin
        if (w_phase_end) begin
          r_div_cnt <= '0;
          r_mdc     <= ~r_mdc;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end

        if (w_bit_end) begin
          r_bit_cnt <= r_bit_cnt + 6'd1;
          case (r_state)
            S_PRE: begin
              if (r_bit_cnt == PRE_LAST) begin
                r_state   <= S_HDR;
                r_bit_cnt <= 6'd0;
                r_out     <= r_shift[31];
                r_shift   <= w_shift_next;
              end
            end
            S_HDR: begin
              r_out   <= r_shift[31];
              r_shift <= w_shift_next;
              if (r_bit_cnt == HDR_LAST) begin
                r_state   <= S_TA;
                r_bit_cnt <= 6'd0;
                // Reads hand the pad to the PHY from TA onwards.
                r_out_en  <= r_rd;
              end
            end
            S_TA: begin
              r_out   <= r_shift[31];
              r_shift <= w_shift_next;
              if (r_bit_cnt == TA_LAST) begin
                // A responding PHY pulls the second TA bit low.
                r_ta_err  <= r_sync2;
                r_state   <= S_DATA;
                r_bit_cnt <= 6'd0;
              end
            end
            S_DATA: begin
              r_rd_shift <= {r_rd_shift[14:0], r_sync2};
              if (r_bit_cnt == DATA_LAST) begin
                r_state     <= S_IDLE;
                r_bit_cnt   <= 6'd0;
                r_out       <= 1'b0;
                r_out_en    <= 1'b1;
                r_rsp_valid <= 1'b1;
                if (r_rd) begin
                  r_rsp_rdata <= {r_rd_shift[14:0], r_sync2};
                  r_rsp_err   <= r_ta_err;
                end
              end else begin
                r_out   <= r_shift[31];
                r_shift <= w_shift_next;
              end
            end
            default: begin
              r_state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign busy        = w_busy;
  assign req_ready   = ~w_busy;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign mdio_clk    = r_mdc;
  assign mdio_out    = r_out;
  assign mdio_out_en = r_out_en;

endmodule

// File: doc/mdio_master.md
# mdio_master

Clause-22 MDIO management master that generates MDC and serialises PHY register read/write frames. It sits between the MAC control logic and the pad mux, and drives the `mdio_clk`, `mdio_out` and `mdio_out_en` pad signals. It samples `mdio_in` from the MDID pad. One transaction is in flight at a time, using a valid/ready request and a single-cycle response pulse.

## Interface
Parameters:
- `DIV_W`, default 8: width of the MDC divider configuration.

Ports:
- `mclk`  in  1  block clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_clk_div`  in  DIV_W  MDC half-period minus one, in mclk cycles. Latched at request acceptance.
- `cfg_pre_en`  in  1  1 = send the 32-bit preamble. Latched at request acceptance.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle; request accepted when `req_valid & req_ready`.
- `req_rd`  in  1  1 = read, 0 = write.
- `req_phy`  in  5  PHY address.
- `req_reg`  in  5  register address.
- `req_wdata`  in  16  write data.
- `rsp_valid`  out  1  one-cycle pulse at transaction end.
- `rsp_rdata`  out  16  read data, held until the next read completes.
- `rsp_err`  out  1  read TA check failed, held with `rsp_rdata`.
- `busy`  out  1  transaction in progress.
- `mdio_clk`  out  1  MDC to pad.
- `mdio_out`  out  1  MDIO data to pad.
- `mdio_out_en`  out  1  pad output-enable, active-low: 0 drives the pad, 1 releases it.
- `mdio_in`  in  1  MDIO data from pad; asynchronous.

## Operation
- The FSM has five states: IDLE, PRE, HDR, TA, DATA.
- IDLE → PRE on accept if `cfg_pre_en` is set; otherwise IDLE → HDR. PRE → HDR after 32 bits. HDR → TA after 14 bits. TA → DATA after 2 bits. DATA → IDLE after 16 bits.
- The acceptance edge latches `req_*`, `cfg_clk_div` and `cfg_pre_en`. Config changes mid-transaction have no effect.
- Bit stream is MSB first:
  - PRE: 32 × 1.
  - HDR: ST = 0,1; OP = 1,0 for read or 0,1 for write; then `req_phy[4:0]`, then `req_reg[4:0]`.
  - Write: TA = 1,0, then `req_wdata[15:0]`.
  - Read: TA and DATA are released.
- `mdio_out_en` is 0 in PRE and HDR, and for the whole of a write. It is 1 in TA and DATA of a read, and 1 in IDLE.
- `mdio_in` passes through a 2-flop synchroniser.
- Read sampling uses the synchronised value at the last mclk edge of each MDC high phase:
  - TA bit 2 is sampled into an error flag; `rsp_err` is set if it is 1.
  - The 16 DATA bits shift into `rsp_rdata`, MSB first.
- The shift register, bit counter (6 bits, 0–63) and divider counter (DIV_W) all reload on accept.
- `rsp_rdata` and `rsp_err` update only on read completion. A write leaves them unchanged.

## Timing
- Reset values: `mdio_clk` = 0, `mdio_out` = 0, `mdio_out_en` = 1, `busy` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `req_ready` = 1. FSM state is IDLE.
- Each bit lasts 2·(D+1) mclk cycles, where D is the latched `cfg_clk_div`:
  - Low phase of D+1 cycles, then high phase of D+1 cycles.
  - `mdio_out` and `mdio_out_en` change only on the edge that starts a low phase, i.e. the MDC falling edge.
  - The first bit is driven on the acceptance edge itself.
- `mdio_clk` idles low. It is 0 in IDLE and never glitches.
- Latency from acceptance edge to the `rsp_valid` edge is N·2·(D+1) cycles, with N = 64 (preamble) or 32 (no preamble). On that edge:
  - FSM returns to IDLE; `mdio_clk` = 0, `mdio_out_en` = 1, `busy` = 0, `req_ready` = 1.
  - A new request may be accepted in the same cycle `rsp_valid` is high (back-to-back).
- `req_ready` = !`busy`, combinational from state.
- D = 0 is legal: MDC = mclk/2.
- Reads require the PHY to drive valid data at least 3 mclk before the end of the high phase, so D ≥ 2 is needed for reads.
- Asserting `reset` mid-transaction forces all reset values immediately. No `rsp_valid` is produced, and the pad is released.

## Test plan
- Reset: hold `reset` for 5 cycles with random inputs → all outputs at reset values; `req_ready` = 1; `mdio_clk` stays low.
- Write, D = 0, preamble on, phy = 5'h01, reg = 5'h00, wdata = 16'h1234:
  - Sample `mdio_out` on each `mdio_clk` rise → 32 ones, then 0101 00001 00000 10 0001001000110100.
  - `mdio_out_en` = 0 throughout; `rsp_valid` arrives 128 cycles after accept; `rsp_rdata` unchanged.
- Read, D = 2, preamble off, phy = 5'h1F, reg = 5'h02; PHY model drives TA2 = 0 and data 16'h0141 on MDC rise:
  - `rsp_rdata` = 16'h0141, `rsp_err` = 0, `rsp_valid` 192 cycles after accept.
  - `mdio_out_en` = 1 for the last 18 bits.
- Read with no PHY (`mdio_in` held 1), D = 3 → `rsp_rdata` = 16'hFFFF, `rsp_err` = 1.
- Back-to-back with `req_valid` held high:
  - Second request is accepted on the `rsp_valid` cycle.
  - `cfg_clk_div` changed from 1 to 5 mid-transaction → MDC period stays 4 cycles until the next accept, then becomes 12.
- Reset asserted at bit 40 of a write → outputs at reset values on the same cycle, no `rsp_valid`. A following write of 16'hABCD completes with a correct full frame.
